// File: rtl/mac_pkg.sv
// rtl/mac_pkg.sv - shared types and width constants for the MAC accumulate stage
package mac_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } mac_state_e;

    localparam int PROD_W = 32;
    localparam int ACC_W  = 36;
    localparam int LEN_W  = 8;

    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

endpackage

// File: rtl/sat_add.sv
// rtl/sat_add.sv - combinational signed saturating adder with overflow flag
module sat_add #(
    parameter int W = 36
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum,
    output logic         ovf
);

    localparam logic [W-1:0] SAT_MAX = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] SAT_MIN = {1'b1, {(W-1){1'b0}}};

    logic [W:0] wide;

    // One guard bit: overflow shows up as disagreement between the two top bits.
    always_comb begin
        wide = {a[W-1], a} + {b[W-1], b};
        ovf  = wide[W] ^ wide[W-1];
        if (!ovf) begin
            sum = wide[W-1:0];
        end else if (wide[W]) begin
            sum = SAT_MIN;
        end else begin
            sum = SAT_MAX;
        end
    end

endmodule

// File: rtl/mac_accumulator.sv
// rtl/mac_accumulator.sv - counted saturating accumulator of signed products with valid/ready ports
module mac_accumulator
    import mac_pkg::*;
#(
    parameter int PROD_W = mac_pkg::PROD_W,
    parameter int ACC_W  = mac_pkg::ACC_W,
    parameter int LEN_W  = mac_pkg::LEN_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    input  logic              abort,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_prod,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_acc,
    output logic              out_sat,
    output logic              busy
);

    mac_state_e        state_q;
    logic [LEN_W-1:0]  rem_q;
    logic [ACC_W-1:0]  acc_q;
    logic              sat_q;
    logic              in_ready_q;
    logic              out_valid_q;
    logic              busy_q;

    logic [ACC_W-1:0]  prod_ext;
    logic [ACC_W-1:0]  acc_d;
    logic              ovf;
    logic              sat_d;

    assign prod_ext = {{(ACC_W-PROD_W){in_prod[PROD_W-1]}}, in_prod};

    sat_add #(
        .W (ACC_W)
    ) u_sat_add (
        .a   (acc_q),
        .b   (prod_ext),
        .sum (acc_d),
        .ovf (ovf)
    );

    assign sat_d = sat_q | ovf;

    // Handshake flags are registered alongside the state so no input reaches them combinationally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            rem_q       <= '0;
            acc_q       <= '0;
            sat_q       <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        rem_q   <= len;
                        acc_q   <= '0;
                        sat_q   <= 1'b0;
                        busy_q  <= 1'b1;
                        if (len != '0) begin
                            state_q    <= ST_ACCUM;
                            in_ready_q <= 1'b1;
                        end else begin
                            state_q     <= ST_DONE;
                            out_valid_q <= 1'b1;
                        end
                    end
                end
                ST_ACCUM: begin
                    if (abort) begin
                        state_q    <= ST_IDLE;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b0;
                    end else if (in_valid) begin
                        acc_q <= acc_d;
                        sat_q <= sat_d;
                        rem_q <= rem_q - LEN_W'(1);
                        if (rem_q == LEN_W'(1)) begin
                            state_q     <= ST_DONE;
                            in_ready_q  <= 1'b0;
                            out_valid_q <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    if (abort || out_ready) begin
                        state_q     <= ST_IDLE;
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    in_ready_q  <= 1'b0;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_acc   = acc_q;
    assign out_sat   = sat_q;
    assign busy      = busy_q;

endmodule
